// File: rtl/ecc_102_pkg.sv
// Shared constants and SECDED parity helpers for the 102-bit FIFO write-side encoder.
package ecc_102_pkg;

  localparam int unsigned DATA_WIDTH   = 102;
  localparam int unsigned PARITY_WIDTH = 8;
  localparam int unsigned HAM_BITS     = 7;

  // Codeword position of data bit k: the (k+1)-th integer >= 3 that is not a power of two.
  function automatic int unsigned ecc_102_pos(input int unsigned k);
    int unsigned pos;
    int unsigned n;
    pos = 3;
    n   = 0;
    for (int unsigned p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

  // Walks positions incrementally; after a power of two (>= 4) the next integer never is one.
  function automatic logic [PARITY_WIDTH-1:0] ecc_102_parity(input logic [DATA_WIDTH-1:0] data);
    logic [PARITY_WIDTH-1:0] par;
    int unsigned             pos;
    par = '0;
    pos = 2;
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      pos = pos + 1;
      if ((pos & (pos - 1)) == 0) pos = pos + 1;
      for (int unsigned i = 0; i < HAM_BITS; i++) begin
        if (pos[i]) par[i] = par[i] ^ data[k];
      end
    end
    par[PARITY_WIDTH-1] = (^data) ^ (^par[HAM_BITS-1:0]);
    return par;
  endfunction

endpackage

// File: rtl/ecc_102_enc_fault_detc_enc.sv
// Combinational 102-bit data to 8-bit SECDED parity generator (one redundant copy).
module ecc_102_enc
  import ecc_102_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [PARITY_WIDTH-1:0] parity
);

  always_comb begin
    parity = ecc_102_parity(data);
  end

endmodule

// File: rtl/ecc_102_enc_fault_detc.sv
// Write-side SECDED encoder with duplicated parity generation, compare and fault status.
// Optional macro ECC_ENC_ERR_INJ_EN adds inj_sbit/inj_dbit error-injection inputs.
module ecc_102_enc_fault_detc
  import ecc_102_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    bypass,
  input  logic                    ecc_fault_detc_en,
`ifdef ECC_ENC_ERR_INJ_EN
  input  logic                    inj_sbit,
  input  logic                    inj_dbit,
`endif
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [PARITY_WIDTH-1:0] parity_out,
  output logic                    ecc_fault,
  output logic                    fault_sts,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  input  logic                    fault_clr
);

  logic [PARITY_WIDTH-1:0] par0, par1;
  logic                    accept, beat_fault;
  logic [DATA_WIDTH-1:0]   data_load;

  logic                    out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [PARITY_WIDTH-1:0] parity_q, parity_d;
  logic                    fault_q, fault_d;
  logic                    sts_q, sts_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  ecc_102_enc u0_ecc_102_enc (.data(data_in), .parity(par0));
  ecc_102_enc u1_ecc_102_enc (.data(data_in), .parity(par1));

  always_comb begin
    in_rdy     = ~out_vld_q | out_rdy;
    accept     = in_vld & in_rdy;
    beat_fault = (|(par0 ^ par1)) & ecc_fault_detc_en & ~bypass;

    // Injection corrupts only the stored payload; parity is always from clean data.
    data_load = data_in;
`ifdef ECC_ENC_ERR_INJ_EN
    if (!bypass) begin
      if (inj_dbit)      data_load[1:0] = ~data_in[1:0];
      else if (inj_sbit) data_load[0]   = ~data_in[0];
    end
`endif

    out_vld_d = out_vld_q;
    data_d    = data_q;
    parity_d  = parity_q;
    fault_d   = fault_q;
    if (accept) begin
      out_vld_d = 1'b1;
      data_d    = data_load;
      parity_d  = bypass ? '0 : par0;
      fault_d   = beat_fault;
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end

    sts_d = sts_q;
    cnt_d = cnt_q;
    if (fault_clr) begin
      sts_d = 1'b0;
      cnt_d = '0;
    end else if (accept && beat_fault) begin
      sts_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      data_q    <= '0;
      parity_q  <= '0;
      fault_q   <= 1'b0;
      sts_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      fault_q   <= fault_d;
      sts_q     <= sts_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign data_out   = data_q;
  assign parity_out = parity_q;
  assign ecc_fault  = fault_q;
  assign fault_sts  = sts_q;
  assign fault_cnt  = cnt_q;

endmodule

// File: tb/tb_ecc_102_enc_fault_detc.sv
// Directed bench for ecc_102_enc_fault_detc; covers ECC_ENC_ERR_INJ_EN when that macro is defined.
module tb_ecc_102_enc_fault_detc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_vld;
  logic         in_rdy;
  logic [101:0] data_in;
  logic         bypass;
  logic         ecc_fault_detc_en;
`ifdef ECC_ENC_ERR_INJ_EN
  logic         inj_sbit;
  logic         inj_dbit;
`endif
  logic         out_vld;
  logic         out_rdy;
  logic [101:0] data_out;
  logic [7:0]   parity_out;
  logic         ecc_fault;
  logic         fault_sts;
  logic [7:0]   fault_cnt;
  logic         fault_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ecc_102_enc_fault_detc #(.CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .data_in(data_in),
    .bypass(bypass), .ecc_fault_detc_en(ecc_fault_detc_en),
`ifdef ECC_ENC_ERR_INJ_EN
    .inj_sbit(inj_sbit), .inj_dbit(inj_dbit),
`endif
    .out_vld(out_vld), .out_rdy(out_rdy), .data_out(data_out), .parity_out(parity_out),
    .ecc_fault(ecc_fault), .fault_sts(fault_sts), .fault_cnt(fault_cnt), .fault_clr(fault_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [101:0] d);
    data_in = d;
    in_vld  = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; data_in = '0; bypass = 1'b0;
    ecc_fault_detc_en = 1'b1; out_rdy = 1'b1; fault_clr = 1'b0;
`ifdef ECC_ENC_ERR_INJ_EN
    inj_sbit = 1'b0; inj_dbit = 1'b0;
`endif
    tick(); tick();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_data", data_out, 0);
    chk("rst_parity", parity_out, 0);
    chk("rst_fault", ecc_fault, 0);
    chk("rst_sts", fault_sts, 0);
    chk("rst_cnt", fault_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Encoding vectors, back-to-back at full throughput
    beat(102'h0);
    chk("enc0_vld", out_vld, 1);
    chk("enc0_par", parity_out, 8'h00);
    beat(102'h1);
    chk("enc_d0_par", parity_out, 8'h83);
    chk("enc_d0_data", data_out, 102'h1);
    beat(102'h2);
    chk("enc_d1_par", parity_out, 8'h85);
    beat(102'h3);
    chk("enc_d01_par", parity_out, 8'h06);
    beat(102'h10);
    chk("enc_d4_par", parity_out, 8'h89);
    beat(102'h1 << 101);
    chk("enc_d101_par", parity_out, 8'h6D);
    chk("enc_d101_fault", ecc_fault, 0);

    // Backpressure: A accepted, then stall 3 cycles with B pending
    beat(102'h1);
    chk("bp_a_data", data_out, 102'h1);
    data_in = 102'h2;
    out_rdy = 1'b0;
    #1;
    chk("bp_rdy_low", in_rdy, 0);
    tick();
    chk("bp_hold1_data", data_out, 102'h1);
    chk("bp_hold1_par", parity_out, 8'h83);
    tick();
    chk("bp_hold2_vld", out_vld, 1);
    tick();
    chk("bp_hold3_data", data_out, 102'h1);
    out_rdy = 1'b1;
    #1;
    chk("bp_rdy_high", in_rdy, 1);
    tick();
    chk("bp_b_data", data_out, 102'h2);
    chk("bp_b_par", parity_out, 8'h85);
    beat(102'h4);
    chk("bp_c_par", parity_out, 8'h86);
    beat(102'h8);
    chk("bp_d_par", parity_out, 8'h07);
    in_vld = 1'b0;
    tick();
    chk("bp_drain_vld", out_vld, 0);

    // Forced mismatch on u1 parity bit 3
    force dut.par1 = 8'h08;
    beat(102'h0);
    chk("flt_en_fault", ecc_fault, 1);
    chk("flt_en_par", parity_out, 8'h00);
    chk("flt_en_sts", fault_sts, 1);
    chk("flt_en_cnt", fault_cnt, 1);
    ecc_fault_detc_en = 1'b0;
    beat(102'h0);
    chk("flt_dis_fault", ecc_fault, 0);
    chk("flt_dis_cnt", fault_cnt, 1);
    ecc_fault_detc_en = 1'b1;
    bypass = 1'b1;
    beat(102'h1);
    chk("byp_par", parity_out, 8'h00);
    chk("byp_fault", ecc_fault, 0);
    chk("byp_data", data_out, 102'h1);
    chk("byp_cnt", fault_cnt, 1);
    bypass = 1'b0;

    // Counter saturation and clear priority
    in_vld = 1'b0;
    fault_clr = 1'b1;
    tick();
    chk("clr_cnt", fault_cnt, 0);
    chk("clr_sts", fault_sts, 0);
    fault_clr = 1'b0;
    data_in = 102'h0;
    in_vld = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    chk("sat255_cnt", fault_cnt, 255);
    for (int i = 0; i < 5; i++) tick();
    chk("sat260_cnt", fault_cnt, 255);
    chk("sat260_sts", fault_sts, 1);
    fault_clr = 1'b1;
    tick();
    chk("clrpri_cnt", fault_cnt, 0);
    chk("clrpri_sts", fault_sts, 0);
    chk("clrpri_fault", ecc_fault, 1);
    fault_clr = 1'b0;
    tick();
    chk("post_clr_cnt", fault_cnt, 1);
    release dut.par1;
    beat(102'h2);
    chk("release_fault", ecc_fault, 0);
    chk("release_par", parity_out, 8'h85);

    // Asynchronous reset with a stalled beat pending
    out_rdy = 1'b0;
    beat(102'h1);
    in_vld = 1'b0;
    chk("arst_pre_vld", out_vld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", out_vld, 0);
    chk("arst_data", data_out, 0);
    chk("arst_par", parity_out, 0);
    chk("arst_cnt", fault_cnt, 0);
    chk("arst_sts", fault_sts, 0);
    tick();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    #1;
    chk("arst_rdy", in_rdy, 1);
    tick();
    chk("arst_no_stale", out_vld, 0);

`ifdef ECC_ENC_ERR_INJ_EN
    inj_dbit = 1'b1;
    beat(102'h0);
    chk("inj_d_data", data_out, 102'h3);
    chk("inj_d_par", parity_out, 8'h00);
    inj_sbit = 1'b1;
    beat(102'h0);
    chk("inj_both_data", data_out, 102'h3);
    inj_dbit = 1'b0;
    beat(102'h2);
    chk("inj_s_data", data_out, 102'h3);
    chk("inj_s_par", parity_out, 8'h85);
    bypass = 1'b1;
    beat(102'h0);
    chk("inj_byp_data", data_out, 102'h0);
    bypass = 1'b0;
    inj_sbit = 1'b0;
    in_vld = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
